hd44780_bus_reader: RTL and testbench

Read-side bus master for the HD44780 LCD interface. It executes one HD44780 read cycle per request (RW=1), producing correctly timed E pulses and sampling the data bus, in either 4-bit or 8-bit bus mode. It returns the byte with a one-cycle done pulse. It sits beside the write path in the LCD controller and is used for busy-flag/address polling (RS=0) and DDRAM/CGRAM readback (RS=1).

---
 rtl/hd44780_bus_reader.sv | 160 ++++++++++++++++
 tb/tb_hd44780_bus_reader.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/hd44780_bus_reader.sv
// HD44780 read-side bus master: one timed RW=1 cycle per request on a 4- or 8-bit bus,
// returning the sampled byte with a single-cycle done pulse.
module hd44780_bus_reader #(
   parameter int unsigned BUS4      = 1,
   parameter int unsigned SETUP_CYC = 2,
   parameter int unsigned EHIGH_CYC = 12,
   parameter int unsigned ELOW_CYC  = 12
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req,
   input  logic       rs_sel,
   output logic       busy,
   output logic       done,
   output logic [7:0] rdata,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic       lcd_e,
   output logic       lcd_db_oe,
   input  logic [7:0] lcd_db_in
);

   localparam int unsigned MAX_AB  = (SETUP_CYC > EHIGH_CYC) ? SETUP_CYC : EHIGH_CYC;
   localparam int unsigned MAX_CYC = (MAX_AB > ELOW_CYC) ? MAX_AB : ELOW_CYC;
   localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_EHIGH,
      ST_ELOW,
      ST_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               second_q, second_d;
   logic               rs_q, rs_d;
   logic [7:0]         samp_q, samp_d;
   logic [7:0]         rdata_q, rdata_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               lcd_rs_q, lcd_rs_d;
   logic               lcd_rw_q, lcd_rw_d;
   logic               lcd_e_q, lcd_e_d;
   logic               active_d;

   // Low data lines are only consumed in 8-bit mode.
   logic unused_db;
   assign unused_db = ^lcd_db_in[3:0];

   // Next-state, timing counter, nibble assembly; outputs are pre-decoded from state_d
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      second_d = second_q;
      rs_d     = rs_q;
      samp_d   = samp_q;
      rdata_d  = rdata_q;

      case (state_q)
         ST_IDLE: begin
            if (req) begin
               state_d  = ST_SETUP;
               cnt_d    = CNT_W'(SETUP_CYC - 1);
               rs_d     = rs_sel;
               second_d = 1'b0;
            end
         end
         ST_SETUP: begin
            if (cnt_q == '0) begin
               state_d = ST_EHIGH;
               cnt_d   = CNT_W'(EHIGH_CYC - 1);
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_EHIGH: begin
            if (cnt_q == '0) begin
               state_d = ST_ELOW;
               cnt_d   = CNT_W'(ELOW_CYC - 1);
               if (BUS4 == 0) begin
                  samp_d = lcd_db_in;
               end else if (second_q) begin
                  samp_d = {samp_q[7:4], lcd_db_in[7:4]};
               end else begin
                  samp_d = {lcd_db_in[7:4], samp_q[3:0]};
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_ELOW: begin
            if (cnt_q == '0) begin
               // RS/RW are still stable, so the second nibble skips SETUP
               if ((BUS4 != 0) && !second_q) begin
                  second_d = 1'b1;
                  state_d  = ST_EHIGH;
                  cnt_d    = CNT_W'(EHIGH_CYC - 1);
               end else begin
                  state_d = ST_DONE;
                  rdata_d = samp_q;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      active_d = (state_d == ST_SETUP) || (state_d == ST_EHIGH) || (state_d == ST_ELOW);
      busy_d   = active_d;
      lcd_rw_d = active_d;
      lcd_rs_d = active_d & rs_d;
      lcd_e_d  = (state_d == ST_EHIGH);
      done_d   = (state_d == ST_DONE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         second_q <= 1'b0;
         rs_q     <= 1'b0;
         samp_q   <= 8'h00;
         rdata_q  <= 8'h00;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         lcd_rs_q <= 1'b0;
         lcd_rw_q <= 1'b0;
         lcd_e_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         second_q <= second_d;
         rs_q     <= rs_d;
         samp_q   <= samp_d;
         rdata_q  <= rdata_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         lcd_rs_q <= lcd_rs_d;
         lcd_rw_q <= lcd_rw_d;
         lcd_e_q  <= lcd_e_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign rdata     = rdata_q;
   assign lcd_rs    = lcd_rs_q;
   assign lcd_rw    = lcd_rw_q;
   assign lcd_e     = lcd_e_q;
   assign lcd_db_oe = 1'b0;

endmodule

// File: tb/tb_hd44780_bus_reader.sv
// Bench for hd44780_bus_reader: a 4-bit default instance and an 8-bit short-timing instance,
// driven by an LCD-side model that only presents valid data in the last E-high cycle.
module tb_hd44780_bus_reader;

   localparam int S4 = 2, H4 = 12, L4 = 12;
   localparam int S8 = 1, H8 = 3,  L8 = 2;
   localparam int LIMIT = 200;

   logic       clk = 1'b0;
   logic       rst;
   logic       req4, rs4, busy4, done4, lcd_rs4, lcd_rw4, e4, oe4;
   logic [7:0] db4, rdata4;
   logic       req8, rs8, busy8, done8, lcd_rs8, lcd_rw8, e8, oe8;
   logic [7:0] db8, rdata8;

   int unsigned total = 0;
   int unsigned bad   = 0;
   logic [7:0]  exp4  = 8'h00;
   logic [7:0]  exp8  = 8'h00;

   always #5 clk = ~clk;

   hd44780_bus_reader u_dut4 (
      .clk(clk), .rst(rst), .req(req4), .rs_sel(rs4), .busy(busy4), .done(done4),
      .rdata(rdata4), .lcd_rs(lcd_rs4), .lcd_rw(lcd_rw4), .lcd_e(e4),
      .lcd_db_oe(oe4), .lcd_db_in(db4)
   );

   hd44780_bus_reader #(.BUS4(0), .SETUP_CYC(S8), .EHIGH_CYC(H8), .ELOW_CYC(L8)) u_dut8 (
      .clk(clk), .rst(rst), .req(req8), .rs_sel(rs8), .busy(busy8), .done(done8),
      .rdata(rdata8), .lcd_rs(lcd_rs8), .lcd_rw(lcd_rw8), .lcd_e(e8),
      .lcd_db_oe(oe8), .lcd_db_in(db8)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, want %0h", tag, got, exp);
      end
   endtask

   task automatic drive(input bit four, input logic r, input logic s, input logic [7:0] d);
      if (four) begin
         req4 = r; rs4 = s; db4 = d;
      end else begin
         req8 = r; rs8 = s; db8 = d;
      end
   endtask

   // Called at the negedge of an IDLE cycle; the next posedge is the accepting edge.
   task automatic do_read(input bit four, input bit rs, input logic [7:0] val,
                          input bit keep_req, input bit glitch);
      int s, h, l, n_done, n_done_exp, rise1, rise2, pulses, hi_cnt;
      int errs_hold, errs_rd, width_err;
      logic b, d, r, w, e, oe, e_prev, rq;
      logic [7:0] rd, old, dbv;
      bit finished;

      s = four ? S4 : S8;
      h = four ? H4 : H8;
      l = four ? L4 : L8;
      n_done_exp = 1 + s + (h + l) * (four ? 2 : 1);
      old = four ? exp4 : exp8;

      b = four ? busy4 : busy8;
      d = four ? done4 : done8;
      e = four ? e4 : e8;
      chk("idle_before", {29'd0, b, d, e}, 32'd0);
      drive(four, 1'b1, rs, 8'($urandom));

      e_prev = 1'b0; pulses = 0; rise1 = -1; rise2 = -1; hi_cnt = 0;
      errs_hold = 0; errs_rd = 0; width_err = 0; finished = 1'b0; n_done = -1;
      for (int n = 1; n <= LIMIT && !finished; n++) begin
         @(negedge clk);
         b  = four ? busy4   : busy8;
         d  = four ? done4   : done8;
         r  = four ? lcd_rs4 : lcd_rs8;
         w  = four ? lcd_rw4 : lcd_rw8;
         e  = four ? e4      : e8;
         oe = four ? oe4     : oe8;
         rd = four ? rdata4  : rdata8;
         if (n == 1) chk("busy_after_accept", {31'd0, b}, 32'd1);
         if (e && !e_prev) begin
            pulses++;
            hi_cnt = 0;
            if (pulses == 1) rise1 = n; else rise2 = n;
         end
         if (!e && e_prev && hi_cnt != h) width_err++;
         if (e) hi_cnt++;
         e_prev = e;
         if (d) begin
            finished = 1'b1;
            n_done = n;
            chk("rdata_at_done", {24'd0, rd}, {24'd0, val});
            chk("outs_at_done", {28'd0, b, w, r, e}, 32'd0);
         end else begin
            if (!(b && w && (r == rs) && !oe)) errs_hold++;
            if (rd !== old) errs_rd++;
            // Valid data only in the final E-high cycle of each pulse; noise elsewhere.
            dbv = 8'($urandom);
            if (e && hi_cnt == h) begin
               if (!four)            dbv = val;
               else if (pulses == 1) dbv = {val[7:4], dbv[3:0]};
               else                  dbv = {val[3:0], dbv[3:0]};
            end
            rq = keep_req || (glitch && n == s + 3);
            drive(four, rq, 1'($urandom), dbv);
         end
      end

      if (!finished) chk("done_timeout", 32'd0, 32'd1);
      chk("done_cycle", 32'(n_done), 32'(n_done_exp));
      chk("e_pulses", 32'(pulses), four ? 32'd2 : 32'd1);
      chk("e_first_rise", 32'(rise1), 32'(1 + s));
      if (four) chk("e_rise_gap", 32'(rise2 - rise1), 32'(h + l));
      chk("e_width_errs", 32'(width_err), 32'd0);
      chk("rs_rw_busy_hold_errs", 32'(errs_hold), 32'd0);
      chk("rdata_early_change", 32'(errs_rd), 32'd0);
      if (four) exp4 = val; else exp8 = val;
   endtask

   initial begin
      int ndone, pulses;
      bit found;
      logic ep;

      rst = 1'b0;
      drive(1'b1, 1'b1, 1'b1, 8'hFF);
      drive(1'b0, 1'b1, 1'b1, 8'hFF);
      repeat (3) @(negedge clk);
      chk("rst_outs4", {18'd0, busy4, done4, lcd_rs4, lcd_rw4, e4, oe4, rdata4}, 32'd0);
      chk("rst_outs8", {18'd0, busy8, done8, lcd_rs8, lcd_rw8, e8, oe8, rdata8}, 32'd0);

      // Release with req4 high: the first edge must accept.
      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 8'h00);
      do_read(1'b1, 1'b0, 8'hB5, 1'b0, 1'b0);

      @(negedge clk);
      do_read(1'b0, 1'b1, 8'h80, 1'b0, 1'b0);

      // Back-to-back with req held high throughout.
      @(negedge clk);
      do_read(1'b1, 1'b0, 8'h12, 1'b1, 1'b0);
      @(negedge clk);
      do_read(1'b1, 1'b1, 8'h34, 1'b1, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 8'h00);

      // A req pulse while busy must not start anything.
      @(negedge clk);
      do_read(1'b1, 1'b1, 8'($urandom), 1'b0, 1'b1);

      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         do_read(1'($urandom), 1'($urandom), 8'($urandom), 1'b0, 1'($urandom));
      end

      // Abort during the second E pulse of a 4-bit read.
      @(negedge clk);
      drive(1'b1, 1'b1, 1'b0, 8'h00);
      found = 1'b0; pulses = 0; ep = 1'b0;
      for (int n = 1; n <= LIMIT && !found; n++) begin
         @(negedge clk);
         drive(1'b1, 1'b0, 1'($urandom), 8'($urandom));
         if (e4 && !ep) pulses++;
         ep = e4;
         if (pulses == 2) found = 1'b1;
      end
      if (!found) chk("abort_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      chk("abort_e_high_before", {31'd0, e4}, 32'd1);
      rst = 1'b0;
      #1;
      chk("abort_e_async_drop", {31'd0, e4}, 32'd0);
      chk("abort_outs", {21'd0, busy4, done4, lcd_rs4, rdata4}, 32'd0);
      exp4 = 8'h00;
      exp8 = 8'h00;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      ndone = 0;
      repeat (60) begin
         @(negedge clk);
         if (done4) ndone++;
      end
      chk("no_done_after_abort", 32'(ndone), 32'd0);
      chk("rdata_after_abort", {24'd0, rdata4}, 32'd0);
      do_read(1'b1, 1'b1, 8'h6C, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
